// File: rtl/pipe_stage_buf_if.sv
// Handshake channel for one side of a pipe_stage_buf: payload, halt sideband, valid/ready.
// The master drives valid/data/halt; the slave drives ready.
interface pipe_stage_buf_if #(
    parameter int unsigned DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              halt;

    modport master (
        output valid,
        output data,
        output halt,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  halt,
        output ready
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Elastic DEPTH-entry pipeline stage with flush and sticky halt.
// Optional PIPE_STAGE_STATS_EN adds saturating stall/bubble cycle counters.
module pipe_stage_buf #(
    parameter int unsigned  DATA_W = 32,
    parameter int unsigned  DEPTH  = 2,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    pipe_stage_buf_if.slave  up,
    pipe_stage_buf_if.master dn,
    output logic             halted,
    output logic [CNT_W-1:0] count
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      bubble_cycles
`endif
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W:0]    r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_halted;

    logic [PTR_W-1:0]   w_wr_ptr_nxt;
    logic [PTR_W-1:0]   w_rd_ptr_nxt;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_halted_nxt;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;
    logic               w_retire;
    logic [DATA_W:0]    w_head;

    // Ready is derived from registered state only, so there is no in-to-out combinational path.
    assign w_in_ready  = (r_count != CNT_W'(DEPTH)) && !r_halted;
    assign w_out_valid = (r_count != '0);
    assign w_accept    = up.valid && w_in_ready;
    assign w_retire    = w_out_valid && dn.ready;
    assign w_head      = r_mem[r_rd_ptr];

    assign up.ready = w_in_ready;
    assign dn.valid = w_out_valid;
    assign dn.data  = w_out_valid ? w_head[DATA_W-1:0] : '0;
    assign dn.halt  = w_out_valid ? w_head[DATA_W] : 1'b0;
    assign halted   = r_halted;
    assign count    = r_count;

    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        // A retire during flush was seen by the consumer, so its halt bit still counts.
        w_halted_nxt = r_halted | (w_retire & w_head[DATA_W]);
        if (flush) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = '0;
        end else begin
            if (w_accept) begin
                w_wr_ptr_nxt = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_retire) begin
                w_rd_ptr_nxt = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_accept && !w_retire) begin
                w_count_nxt = r_count + 1'b1;
            end else if (!w_accept && w_retire) begin
                w_count_nxt = r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_halted <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    // Storage needs no reset: outputs are gated by out_valid.
    always_ff @(posedge CLK) begin
        if (nRST && w_accept && !flush) begin
            r_mem[r_wr_ptr] <= {up.halt, up.data};
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_bubble_cycles;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_stall_cycles  <= '0;
            r_bubble_cycles <= '0;
        end else begin
            if (up.valid && !w_in_ready && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (!w_out_valid && !r_halted && (r_bubble_cycles != '1)) begin
                r_bubble_cycles <= r_bubble_cycles + 1'b1;
            end
        end
    end

    assign stall_cycles  = r_stall_cycles;
    assign bubble_cycles = r_bubble_cycles;
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: DEPTH=2 instance for handshake/flush/halt,
// DEPTH=3 instance for pointer wrap under random downstream backpressure.
module tb_pipe_stage_buf;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush2 = 1'b0;
    logic       flush3 = 1'b0;
    logic       halted2;
    logic       halted3;
    logic [1:0] count2;
    logic [1:0] count3;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall2, bubble2, stall3, bubble3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_buf_if #(.DATA_W(32)) up2 ();
    pipe_stage_buf_if #(.DATA_W(32)) dn2 ();
    pipe_stage_buf_if #(.DATA_W(32)) up3 ();
    pipe_stage_buf_if #(.DATA_W(32)) dn3 ();

    pipe_stage_buf #(.DATA_W(32), .DEPTH(2)) u_dut2 (
        .CLK           (clk),
        .nRST          (rst_n),
        .flush         (flush2),
        .up            (up2),
        .dn            (dn2),
        .halted        (halted2),
        .count         (count2)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cycles  (stall2),
        .bubble_cycles (bubble2)
`endif
    );

    pipe_stage_buf #(.DATA_W(32), .DEPTH(3)) u_dut3 (
        .CLK           (clk),
        .nRST          (rst_n),
        .flush         (flush3),
        .up            (up3),
        .dn            (dn3),
        .halted        (halted3),
        .count         (count3)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cycles  (stall3),
        .bubble_cycles (bubble3)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] b2b [3];
        int sent, recv, mcount, stalls;
        logic acc, ret;

        up2.valid = 1'b1; up2.data = 32'h99; up2.halt = 1'b0; dn2.ready = 1'b0;
        up3.valid = 1'b0; up3.data = '0;     up3.halt = 1'b0; dn3.ready = 1'b0;

        // Reset held with in_valid asserted.
        tick(); tick();
        check("rst_out_valid", dn2.valid, 0);
        check("rst_count", count2, 0);
        check("rst_halted", halted2, 0);
        check("rst_out_data", dn2.data, 0);
        rst_n = 1'b1; up2.valid = 1'b0;
        check("rst_in_ready", up2.ready, 1);

        // Back-to-back with out_ready=1.
        b2b[0] = 32'h11; b2b[1] = 32'h22; b2b[2] = 32'h33;
        dn2.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            up2.valid = 1'b1; up2.data = b2b[i];
            if (i > 0) begin
                check("b2b_data", dn2.data, b2b[i-1]);
                check("b2b_count", count2, 1);
            end
            tick();
        end
        up2.valid = 1'b0;
        check("b2b_data_last", dn2.data, 32'h33);
        tick();
        check("b2b_drain_count", count2, 0);
        check("b2b_drain_valid", dn2.valid, 0);

        // Backpressure to full, then drain in order.
        dn2.ready = 1'b0;
        up2.valid = 1'b1; up2.data = 32'hA; tick();
        up2.data = 32'hB; tick();
        up2.data = 32'hC;
        check("full_count", count2, 2);
        check("full_in_ready", up2.ready, 0);
        check("full_head", dn2.data, 32'hA);
        tick();
        check("stall_head_stable", dn2.data, 32'hA);
        check("stall_count", count2, 2);
        dn2.ready = 1'b1;
        tick();
        check("drain_head_b", dn2.data, 32'hB);
        check("drain_count_1", count2, 1);
        check("drain_in_ready", up2.ready, 1);
        tick();
        up2.valid = 1'b0;
        check("drain_head_c", dn2.data, 32'hC);
        check("drain_count_c", count2, 1);
        tick();
        check("drain_empty", count2, 0);

        // Flush while full and retiring, with 0xD presented.
        dn2.ready = 1'b0;
        up2.valid = 1'b1; up2.data = 32'h44; tick();
        up2.data = 32'h55; tick();
        dn2.ready = 1'b1; flush2 = 1'b1; up2.data = 32'hD;
        tick();
        flush2 = 1'b0; up2.valid = 1'b0;
        check("flush_count", count2, 0);
        check("flush_out_valid", dn2.valid, 0);
        tick();
        check("flush_no_d", dn2.valid, 0);

        // Flush discards a same-cycle accept.
        dn2.ready = 1'b0;
        up2.valid = 1'b1; up2.data = 32'h66; tick();
        flush2 = 1'b1; up2.data = 32'hE;
        check("flush2_in_ready", up2.ready, 1);
        tick();
        flush2 = 1'b0; up2.valid = 1'b0;
        check("flush2_count", count2, 0);

        // Halt: entries ahead of it drain, then halted sticks.
        up2.valid = 1'b1; up2.data = 32'h1; up2.halt = 1'b0; tick();
        up2.data = 32'h2; up2.halt = 1'b1; tick();
        up2.valid = 1'b0; up2.halt = 1'b0;
        dn2.ready = 1'b1;
        check("halt_head1", dn2.data, 32'h1);
        check("halt_head1_bit", dn2.halt, 0);
        tick();
        check("halt_head2", dn2.data, 32'h2);
        check("halt_head2_bit", dn2.halt, 1);
        check("halt_not_yet", halted2, 0);
        tick();
        check("halt_set", halted2, 1);
        check("halt_in_ready", up2.ready, 0);
        up2.valid = 1'b1; up2.data = 32'h3;
        tick();
        check("halt_reject_count", count2, 0);
        check("halt_reject_valid", dn2.valid, 0);
        up2.valid = 1'b0; flush2 = 1'b1;
        tick();
        flush2 = 1'b0;
        check("halt_after_flush", halted2, 1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("halt_cleared_by_rst", halted2, 0);
        check("rst2_in_ready", up2.ready, 1);

        // DEPTH=3 wrap with random out_ready against a bench occupancy model.
        sent = 0; recv = 0; mcount = 0; stalls = 0;
        for (int cyc = 0; cyc < 200 && recv < 7; cyc++) begin
            up3.valid = (sent < 7);
            up3.data  = 32'h100 + sent;
            dn3.ready = 1'($urandom_range(0, 1));
            #1;
            check("wrap_in_ready", up3.ready, (mcount != 3) ? 1 : 0);
            check("wrap_count", count3, mcount);
            acc = up3.valid && (mcount != 3);
            ret = (mcount != 0) && dn3.ready;
            if (up3.valid && mcount == 3) stalls++;
            if (ret) begin
                check("wrap_data", dn3.data, 32'h100 + recv);
                recv++;
            end
            if (acc) sent++;
            mcount = mcount + int'(acc) - int'(ret);
            tick();
        end
        up3.valid = 1'b0;
        check("wrap_all_received", recv, 7);
`ifdef PIPE_STAGE_STATS_EN
        check("wrap_stall_cycles", stall3, stalls);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed MEM/WB latch: one elastic pipeline stage between any two CPU pipeline stages.
- Carries a generic payload word plus a halt sideband, with a valid/ready handshake instead of a bare enable.
- Holds DEPTH entries in FIFO order so an upstream stage can keep issuing while the downstream stage stalls.
- Supports a synchronous flush that inserts bubbles, and a sticky halt that retires cleanly.

Parameters:
- DATA_W, 32, payload width in bits (≥1).
- DEPTH, 2, number of buffered entries (1..8). 1 gives the classic single pipeline latch.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream presents an entry.
- in_ready  out  1  stage will accept an entry this cycle.
- in_data  in  DATA_W  upstream payload.
- in_halt  in  1  entry is a halt instruction.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes the head this cycle.
- out_data  out  DATA_W  head payload.
- out_halt  out  1  halt bit of the head entry.
- flush  in  1  discard all buffered entries.
- halted  out  1  sticky: a halt entry has retired.
- count  out  CNT_W  current occupancy.

Behaviour:
- Reset (nRST=0 at an edge):
  - count=0, read/write pointers=0, halted=0.
  - out_valid=0, out_data=0, out_halt=0.
  - Reset overrides every other input, including mid-transfer.
- Storage:
  - DEPTH-entry circular buffer of {halt, data}.
  - Write pointer and read pointer each wrap from DEPTH-1 to 0. Correct wrap is required for non-power-of-two DEPTH.
- Combinational outputs:
  - in_ready = (count != DEPTH) && !halted. This does not depend on out_ready: no pass-through when full.
  - out_valid = (count != 0).
  - out_data/out_halt = entry at the read pointer when out_valid, else 0.
- Accept: in_valid && in_ready at an edge. Write entry at the write pointer; advance write pointer.
- Retire: out_valid && out_ready at an edge. Advance read pointer.
  - If the retired entry has halt=1, halted<=1 on that edge.
- Simultaneous accept and retire: count unchanged and both pointers advance. This covers an empty-to-nonempty race only in the sense that accepting into empty and retiring in the same cycle is impossible, because out_valid=0 when empty.
- Latency: an entry accepted at edge N is visible on out_* after edge N. Minimum one cycle, no combinational in-to-out path.
- Throughput: one entry per cycle sustained when out_ready=1 and DEPTH ≥ 1, except when DEPTH=1 and full. In that case in_ready=0, giving half rate; this is intended, since the registered ready is kept.
- Flush (flush=1 at an edge):
  - count<=0 and pointers<=0.
  - A same-cycle accept is discarded.
  - A same-cycle retire still counts: the consumer saw it, and its halt bit still sets halted.
  - Flush does not clear halted; only reset does.
- Halted:
  - Once halted=1, in_ready is held at 0.
  - Entries already buffered behind the halt still drain to downstream.
- Handshake rule: out_data/out_halt must be stable while out_valid=1 and out_ready=0 (no flush).

Optional Feature:
- Macro PIPE_STAGE_STATS_EN.
- When defined, two additional output ports:
  - stall_cycles[31:0]: increments each cycle in_valid && !in_ready.
  - bubble_cycles[31:0]: increments each cycle !out_valid && !halted.
  - Both counters saturate at 32'hFFFF_FFFF, reset to 0 on nRST=0, and are not affected by flush.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan (DATA_W=32, DEPTH=2 unless stated):
- Reset: hold nRST=0 for 2 cycles with in_valid=1 → out_valid=0, count=0, halted=0, in_ready=1 after release.
- Back-to-back: out_ready=1, feed 0x11,0x22,0x33 on consecutive cycles → out_data 0x11,0x22,0x33 on the next three cycles, count never above 1.
- Backpressure/full: out_ready=0, feed 0xA,0xB,0xC → count=2, in_ready=0, 0xC held upstream. Raise out_ready → order 0xA,0xB,0xC with no loss, and out_data stable while stalled.
- Flush collision: count=2 and out_ready=1, flush=1 while presenting 0xD → head retired once, count=0 next cycle, 0xD never appears.
- Halt: feed 0x1, 0x2 with in_halt=1, then 0x3 → halted=1 the cycle after 0x2 retires, in_ready stays 0, 0x3 never accepted. A flush afterwards leaves halted=1.
- DEPTH=3 wrap: push/pop 7 entries with random out_ready → output sequence equals input sequence. With PIPE_STAGE_STATS_EN, stall_cycles equals the number of cycles the bench observed in_valid && !in_ready.
